soc_system_pio_strobe_ctrl: RTL

- Parametrised Avalon-MM slave PIO; successor to the 1-bit instruction-enable PIO between HPS lightweight bridge and the zoom coprocessor.
- Generalised to WIDTH output bits, with:
  - atomic set/clear writes;
  - self-clearing strobe pulses of programmable length, so software no longer writes 1-then-0 to launch an instruction;
  - rising-edge capture on a done/ack input bus, with a maskable IRQ.

---
 rtl/soc_system_pio_pkg.sv | 21 ++
 rtl/soc_system_pio_sync.sv | 31 +++
 rtl/soc_system_pio_strobe_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the SoC PIO family: register addresses, STATUS
// field positions and the bus width of the Avalon-MM data path.
package soc_system_pio_pkg;

    localparam int unsigned MAX_WIDTH = 32;
    localparam int unsigned ADDR_W    = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_SET    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_CLEAR  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_PULSE  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_PLEN   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_EDGE   = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_MASK   = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd7;

    localparam int unsigned STATUS_BUSY_BIT  = 0;
    localparam int unsigned STATUS_WIDTH_LSB = 8;
    localparam int unsigned STATUS_WIDTH_W   = 8;

endpackage

// File: rtl/soc_system_pio_sync.sv
// WIDTH-wide, STAGES-deep flop synchroniser for asynchronous inputs.
// Ports: clk, reset (async, active-high), d (async input), q (synchronised).
module soc_system_pio_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    logic [STAGES-1:0][WIDTH-1:0] chain_d;

    // Shift the input one stage deeper each cycle.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/soc_system_pio_strobe_ctrl.sv
// Avalon-MM PIO slave with atomic set/clear, self-clearing strobe pulses and
// optional rising-edge capture with a maskable level IRQ.
// Optional feature macro: PIO_STROBE_EDGE_CAPTURE_EN (edge capture, MASK, irq,
// in_port synchroniser). When undefined EDGE/MASK read 0 and irq is tied 0.
// Ports: clk, reset (async, active-high), address/chipselect/write_n/writedata
// (slave write side), readdata (combinational from address), out_port
// (data | pulse bits), in_port (async status inputs), irq (level).
module soc_system_pio_strobe_ctrl
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned PULSE_W       = 8,
    parameter int unsigned PULSE_DEFAULT = 1,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [MAX_WIDTH-1:0] writedata,
    output logic [MAX_WIDTH-1:0] readdata,
    output logic [WIDTH-1:0]     out_port,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic               wr_en;
    logic [WIDTH-1:0]   wd;
    logic [PULSE_W-1:0] wd_plen;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   pulse_q, pulse_d;
    logic [PULSE_W-1:0] cnt_q, cnt_d;
    logic [PULSE_W-1:0] plen_q, plen_d;
    logic [WIDTH-1:0]   edge_rd;
    logic [WIDTH-1:0]   mask_rd;
    logic               busy;
    logic               unused_bits;

    assign wr_en       = chipselect & ~write_n;
    assign wd          = writedata[WIDTH-1:0];
    assign wd_plen     = writedata[PULSE_W-1:0];
    assign busy        = (pulse_q != '0);
    assign unused_bits = ^{writedata, in_port};

    // Level data register with atomic set/clear.
    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:  data_d = wd;
                ADDR_SET:   data_d = data_q | wd;
                ADDR_CLEAR: data_d = data_q & ~wd;
                default:    data_d = data_q;
            endcase
        end
    end

    // Strobe bits: a nonzero PULSE write ORs bits in and restarts the count;
    // all strobe bits drop together when the count expires.
    always_comb begin
        pulse_d = pulse_q;
        cnt_d   = cnt_q;
        if (wr_en && (address == ADDR_PULSE) && (wd != '0)) begin
            pulse_d = pulse_q | wd;
            cnt_d   = plen_q;
        end else if (busy) begin
            if (cnt_q <= PULSE_W'(1)) begin
                pulse_d = '0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - PULSE_W'(1);
            end
        end
    end

    // Pulse length; zero is promoted to one so a pulse is never empty.
    always_comb begin
        plen_d = plen_q;
        if (wr_en && (address == ADDR_PLEN)) begin
            plen_d = (wd_plen == '0) ? PULSE_W'(1) : wd_plen;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            pulse_q <= '0;
            cnt_q   <= '0;
            plen_q  <= PULSE_W'(PULSE_DEFAULT);
        end else begin
            data_q  <= data_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            plen_q  <= plen_d;
        end
    end

    assign out_port = data_q | pulse_q;

`ifdef PIO_STROBE_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] dly_q, dly_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             irq_q, irq_d;

    soc_system_pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (sync_w)
    );

    // W1C is applied first so a coincident new rise on the same bit wins.
    always_comb begin
        dly_d  = sync_w;
        rise   = sync_w & ~dly_q;
        edge_d = edge_q;
        mask_d = mask_q;
        if (wr_en && (address == ADDR_EDGE)) begin
            edge_d = edge_q & ~wd;
        end
        edge_d = edge_d | rise;
        if (wr_en && (address == ADDR_MASK)) begin
            mask_d = wd;
        end
        irq_d = |(edge_q & mask_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly_q  <= '0;
            edge_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            dly_q  <= dly_d;
            edge_q <= edge_d;
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq     = irq_q;
    assign edge_rd = edge_q;
    assign mask_rd = mask_q;
`else
    assign irq     = 1'b0;
    assign edge_rd = '0;
    assign mask_rd = '0;
`endif

    // Read mux, zero-extended to the bus width.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:  readdata = MAX_WIDTH'(data_q);
            ADDR_PULSE: readdata = MAX_WIDTH'(pulse_q);
            ADDR_PLEN:  readdata = MAX_WIDTH'(plen_q);
            ADDR_EDGE:  readdata = MAX_WIDTH'(edge_rd);
            ADDR_MASK:  readdata = MAX_WIDTH'(mask_rd);
            ADDR_STATUS: begin
                readdata[STATUS_BUSY_BIT] = busy;
                readdata[STATUS_WIDTH_LSB +: STATUS_WIDTH_W] = STATUS_WIDTH_W'(WIDTH);
            end
            default:    readdata = '0;
        endcase
    end

endmodule
